// File: rtl/formula_seq_pkg.sv
// rtl/formula_seq_pkg.sv - shared types and widths for formula_1_seq
package formula_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE_B = 2'd1,
    ISSUE_C = 2'd2
  } state_t;

  // 3 * 65535 = 196605 fits in 18 bits
  localparam int SUM_W = 18;

  typedef logic [1:0] phase_t;

endpackage

// File: rtl/formula_1_seq_isqrt.sv
// rtl/formula_1_seq_isqrt.sv - 16-stage pipelined floor square root, one result bit per stage
module isqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  logic [31:0] op_q  [15];
  logic [31:0] rt_q  [15];
  logic [15:0] y_q;
  logic [15:0] vld_q;

  logic [31:0] op_in [16];
  logic [31:0] rt_in [16];
  logic [31:0] op_d  [16];
  logic [31:0] rt_d  [16];
  logic [15:0] en;
  logic        unused_bits;

  // digit-by-digit root: stage k tests bit (15-k) of the result
  always_comb begin
    op_in[0] = x;
    rt_in[0] = '0;
    en[0]    = x_vld;
    for (int k = 1; k < 16; k++) begin
      op_in[k] = op_q[k-1];
      rt_in[k] = rt_q[k-1];
      en[k]    = vld_q[k-1];
    end
    for (int k = 0; k < 16; k++) begin
      logic [31:0] one;
      logic [31:0] trial;
      one   = 32'd1 << (30 - 2 * k);
      trial = rt_in[k] + one;
      if (op_in[k] >= trial) begin
        op_d[k] = op_in[k] - trial;
        rt_d[k] = (rt_in[k] >> 1) + one;
      end else begin
        op_d[k] = op_in[k];
        rt_d[k] = rt_in[k] >> 1;
      end
    end
  end

  assign unused_bits = ^{op_d[15], rt_d[15][31:16]};

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[14:0], x_vld};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 15; k++) begin
      if (en[k]) begin
        op_q[k] <= op_d[k];
        rt_q[k] <= rt_d[k];
      end
    end
    if (en[15]) y_q <= rt_d[15][15:0];
  end

  assign y_vld = vld_q[15];
  assign y     = y_q;

endmodule

// File: rtl/formula_1_seq.sv
// rtl/formula_1_seq.sv - isqrt(a)+isqrt(b)+isqrt(c) through one time-multiplexed isqrt pipeline
module formula_1_seq
  import formula_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  output logic        arg_rdy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  output logic [31:0] res
);

  state_t            state_q, state_d;
  logic [31:0]       b_q, c_q;
  logic              isq_x_vld;
  logic [31:0]       isq_x;
  logic              isq_y_vld;
  logic [15:0]       isq_y;
  phase_t            phase_q;
  logic [SUM_W-1:0]  acc_q;
  logic [SUM_W-1:0]  res_q;
  logic              res_vld_q;
  logic [SUM_W-1:0]  y_ext;

  assign arg_rdy = (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    isq_x_vld = 1'b0;
    isq_x     = a;
    case (state_q)
      IDLE: begin
        if (arg_vld) begin
          isq_x_vld = 1'b1;
          state_d   = ISSUE_B;
        end
      end
      ISSUE_B: begin
        isq_x     = b_q;
        isq_x_vld = 1'b1;
        state_d   = ISSUE_C;
      end
      ISSUE_C: begin
        isq_x     = c_q;
        isq_x_vld = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (arg_vld && arg_rdy) begin
      b_q <= b;
      c_q <= c;
    end
  end

  isqrt u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .x_vld (isq_x_vld),
    .x     (isq_x),
    .y_vld (isq_y_vld),
    .y     (isq_y)
  );

  assign y_ext = {{(SUM_W-16){1'b0}}, isq_y};

  // results arrive in issue order a, b, c, so the phase alone tells which one
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= 2'd0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      if (isq_y_vld) begin
        case (phase_q)
          2'd0: begin
            acc_q   <= y_ext;
            phase_q <= 2'd1;
          end
          2'd1: begin
            acc_q   <= acc_q + y_ext;
            phase_q <= 2'd2;
          end
          default: begin
            res_q     <= acc_q + y_ext;
            res_vld_q <= 1'b1;
            phase_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign res_vld = res_vld_q;
  assign res     = {{(32-SUM_W){1'b0}}, res_q};

endmodule

// File: tb/tb_formula_1_seq.sv
// tb/tb_formula_1_seq.sv - directed self-checking bench for formula_1_seq
module tb_formula_1_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_vld;
  logic        arg_rdy;
  logic [31:0] a, b, c;
  logic        res_vld;
  logic [31:0] res;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int xcount  = 0;
  int rq_val[$];
  int rq_cyc[$];

  localparam int LAT = 16 + 3;

  formula_1_seq dut (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (arg_vld),
    .arg_rdy (arg_rdy),
    .a       (a),
    .b       (b),
    .c       (c),
    .res_vld (res_vld),
    .res     (res)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (res_vld) begin
      rq_val.push_back(int'(res));
      rq_cyc.push_back(cyc);
    end
    if (dut.isq_x_vld) xcount++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rq_val.delete();
    rq_cyc.delete();
  endtask

  // present one set for a single cycle; returns the cycle it was offered in
  task automatic apply(input logic [31:0] va, vb, vc, output int t);
    a = va; b = vb; c = vc; arg_vld = 1'b1;
    t = cyc;
    check("rdy_on_apply", {31'd0, arg_rdy}, 32'd1);
    step();
    arg_vld = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (rq_val.size() < n && k < 200) begin
      step();
      k++;
    end
    check("result_timeout", {31'd0, rq_val.size() >= n}, 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] va, vb, vc, input logic [31:0] exp);
    int t;
    int x0;
    clear_q();
    x0 = xcount;
    apply(va, vb, vc, t);
    wait_res(1);
    repeat (5) step();
    if (rq_val.size() > 0) begin
      check({tag, "_res"}, rq_val[0], exp);
      check({tag, "_lat"}, rq_cyc[0] - t, LAT);
    end
    check({tag, "_count"}, rq_val.size(), 1);
    check({tag, "_xvld"}, xcount - x0, 3);
  endtask

  initial begin
    int t, t_acc[3], x0, idx;
    logic [31:0] sets[3];
    rst = 1'b1; arg_vld = 1'b0; a = '0; b = '0; c = '0;
    step(); step();
    rst = 1'b0;
    check("reset_rdy", {31'd0, arg_rdy}, 32'd1);
    check("reset_vld", {31'd0, res_vld}, 32'd0);
    check("reset_res", res, 32'd0);

    x0 = xcount;
    repeat (8) step();
    check("idle_xvld", xcount - x0, 0);

    // basic with ready pattern
    clear_q();
    x0 = xcount;
    apply(32'd1, 32'd4, 32'd9, t);
    check("busy_rdy1", {31'd0, arg_rdy}, 32'd0);
    step();
    check("busy_rdy2", {31'd0, arg_rdy}, 32'd0);
    step();
    check("rdy_back", {31'd0, arg_rdy}, 32'd1);
    wait_res(1);
    repeat (5) step();
    if (rq_val.size() > 0) begin
      check("basic_res", rq_val[0], 32'd6);
      check("basic_lat", rq_cyc[0] - t, LAT);
    end
    check("basic_count", rq_val.size(), 1);
    check("basic_xvld", xcount - x0, 3);

    run_one("floor", 32'd16, 32'd15, 32'd0, 32'd7);
    run_one("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0002_FFFD);
    run_one("mixed", 32'd1_000_000, 32'd99, 32'd3, 32'd1010);

    // ignore while busy
    clear_q();
    apply(32'd1, 32'd4, 32'd9, t);
    a = 32'd100; b = 32'd0; c = 32'd0; arg_vld = 1'b1;
    check("ignore_rdy", {31'd0, arg_rdy}, 32'd0);
    step();
    arg_vld = 1'b0;
    wait_res(1);
    repeat (30) step();
    if (rq_val.size() > 0) check("ignore_res", rq_val[0], 32'd6);
    check("ignore_count", rq_val.size(), 1);

    // streaming with arg_vld held high
    clear_q();
    sets[0] = 32'd1; sets[1] = 32'd4; sets[2] = 32'd9;
    idx = 0;
    for (int k = 0; k < 20 && idx < 3; k++) begin
      a = sets[idx]; b = sets[idx]; c = sets[idx]; arg_vld = 1'b1;
      if (arg_rdy) begin
        t_acc[idx] = cyc;
        idx++;
      end
      step();
    end
    arg_vld = 1'b0;
    check("stream_accepted", idx, 3);
    wait_res(3);
    repeat (5) step();
    if (idx == 3) begin
      check("stream_acc1", t_acc[1] - t_acc[0], 3);
      check("stream_acc2", t_acc[2] - t_acc[0], 6);
    end
    check("stream_count", rq_val.size(), 3);
    if (rq_val.size() == 3) begin
      check("stream_res0", rq_val[0], 32'd3);
      check("stream_res1", rq_val[1], 32'd6);
      check("stream_res2", rq_val[2], 32'd9);
      check("stream_gap1", rq_cyc[1] - rq_cyc[0], 3);
      check("stream_gap2", rq_cyc[2] - rq_cyc[1], 3);
      if (idx == 3) check("stream_lat", rq_cyc[0] - t_acc[0], LAT);
    end

    // reset during ISSUE_B flushes the set
    clear_q();
    apply(32'd1, 32'd4, 32'd9, t);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_rdy", {31'd0, arg_rdy}, 32'd1);
    repeat (40) step();
    check("rst_no_res", rq_val.size(), 0);
    run_one("post_rst", 32'd4, 32'd4, 32'd4, 32'd6);

    x0 = xcount;
    repeat (10) step();
    check("idle_xvld_end", xcount - x0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
